// File: rtl/mux_arbiter2_pkg.sv
// rtl/mux_arbiter2_pkg.sv - shared types and constants for the two-way arbiter
package mux_arbiter2_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/mux_arbiter2_rr_pick2.sv
// rtl/mux_arbiter2_rr_pick2.sv - combinational two-way round-robin pick
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic any,
  output logic pick
);

  assign any = req0 | req1;
  // prio only matters on a tie; otherwise the lone requester wins
  assign pick = (req0 & req1) ? prio : req1;

endmodule

// File: rtl/mux_arbiter2.sv
// rtl/mux_arbiter2.sv - round-robin arbiter sharing one registered output port
module mux_arbiter2
  import mux_arbiter2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             src_q;
  logic             prio_q;

  logic any;
  logic pick;
  logic cap;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .prio (prio_q),
    .any  (any),
    .pick (pick)
  );

  // A slot opens when the holding register is empty or is being drained this edge
  assign cap  = !reset && ((state_q == ST_IDLE) || out_ready);
  assign gnt0 = cap && any && !pick;
  assign gnt1 = cap && any && pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      src_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else if (gnt0 || gnt1) begin
      state_q <= ST_FULL;
      data_q  <= gnt1 ? data1 : data0;
      src_q   <= gnt1;
      prio_q  <= !gnt1;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_q <= ST_IDLE;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_mux_arbiter2.sv
// tb/tb_mux_arbiter2.sv - self-checking bench for mux_arbiter2
module tb_mux_arbiter2;

  logic        clk = 1'b0;
  logic        reset, req0, req1, gnt0, gnt1, out_valid, out_src, out_ready;
  logic [31:0] data0, data1, out_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: holding slot contents plus whose turn it is on a tie
  logic        m_full, m_src, m_tie, e_g0, e_g1;
  logic [31:0] m_data;

  logic        q0, q1;
  logic [31:0] d0, d1;

  always #5 clk = ~clk;

  mux_arbiter2 #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle, check grants and held outputs against the model, advance the model
  task automatic step(input logic r, input logic a0, input logic [31:0] v0,
                      input logic a1, input logic [31:0] v1, input logic rdy, input string tag);
    logic slot_open, winner;
    reset = r; req0 = a0; data0 = v0; req1 = a1; data1 = v1; out_ready = rdy;
    #3;
    slot_open = !r && (!m_full || rdy);
    winner    = (a0 && a1) ? m_tie : a1;
    e_g0 = slot_open && (a0 || a1) && !winner;
    e_g1 = slot_open && (a0 || a1) && winner;
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(e_g0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(e_g1));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_full));
    chk({tag, ".data"}, out_data, m_data);
    chk({tag, ".src"}, 32'(out_src), 32'(m_src));
    if (r) begin
      m_full = 1'b0; m_data = 32'd0; m_src = 1'b0; m_tie = 1'b0;
    end else if (e_g0 || e_g1) begin
      m_full = 1'b1; m_data = e_g1 ? v1 : v0; m_src = e_g1; m_tie = !e_g1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; out_ready = 1'b0;
    m_full = 1'b0; m_src = 1'b0; m_tie = 1'b0; m_data = '0; e_g0 = 1'b0; e_g1 = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset holds off grants, first grant right after release
    step(1, 1, 32'd11, 0, 0, 1, "t1_rst");
    step(1, 1, 32'd11, 0, 0, 1, "t1_rst");
    step(0, 1, 32'd11, 0, 0, 1, "t1_first");
    chk("t1_first_valid", 32'(out_valid), 32'd1);

    // 2: single requester latency and drop
    step(1, 0, 0, 0, 0, 1, "t2_rst");
    step(0, 1, 32'd11, 0, 0, 1, "t2_req");
    chk("t2_data", out_data, 32'd11);
    step(0, 0, 0, 0, 0, 1, "t2_drain");
    chk("t2_idle", 32'(out_valid), 32'd0);

    // 3: tie alternates 12, 40, 12, 40 at one word per cycle
    step(1, 0, 0, 0, 0, 1, "t3_rst");
    step(0, 1, 32'd12, 1, 32'd40, 1, "t3_rr");
    chk("t3_w0", out_data, 32'd12);
    step(0, 1, 32'd12, 1, 32'd40, 1, "t3_rr");
    chk("t3_w1", out_data, 32'd40);
    step(0, 1, 32'd12, 1, 32'd40, 1, "t3_rr");
    chk("t3_w2", out_data, 32'd12);
    step(0, 1, 32'd12, 1, 32'd40, 1, "t3_rr");
    chk("t3_w3", out_data, 32'd40);
    chk("t3_src3", 32'(out_src), 32'd1);

    // 4: backpressure holds 110 and withholds grants
    step(1, 0, 0, 0, 0, 1, "t4_rst");
    step(0, 1, 32'd110, 0, 0, 0, "t4_load");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'd1, 0, "t4_hold");
    chk("t4_held", out_data, 32'd110);
    step(0, 0, 0, 1, 32'd1, 1, "t4_release");
    chk("t4_new", out_data, 32'd1);

    // 5: reset in FULL discards the word and restores tie priority to requester 0
    step(1, 0, 0, 0, 0, 1, "t5_rst");
    step(0, 0, 0, 1, 32'd40, 0, "t5_load");
    step(1, 0, 0, 0, 0, 0, "t5_midrst");
    chk("t5_cleared", out_data, 32'd0);
    step(0, 1, 32'd5, 1, 32'd6, 1, "t5_tie");
    chk("t5_tie_src", 32'(out_src), 32'd0);

    // 6: drain to idle, stray ready ignored
    step(1, 0, 0, 0, 0, 1, "t6_rst");
    step(0, 0, 0, 1, 32'd7, 1, "t6_load");
    step(0, 0, 0, 0, 0, 1, "t6_drain");
    step(0, 0, 0, 0, 0, 1, "t6_stray");
    chk("t6_idle", 32'(out_valid), 32'd0);
    chk("t6_kept", out_data, 32'd7);

    // Random traffic honouring the requester contract
    step(1, 0, 0, 0, 0, 1, "rnd_rst");
    q0 = 1'b0; q1 = 1'b0; d0 = '0; d1 = '0;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 40) == 0), q0, d0, q1, d1, ($urandom_range(0, 3) != 0), "rnd");
      if (e_g0) q0 = $urandom_range(0, 1) != 0;
      if (e_g1) q1 = $urandom_range(0, 1) != 0;
      if (e_g0 || (!q0 && $urandom_range(0, 2) == 0)) begin
        q0 = q0 || !e_g0;
        d0 = $urandom;
      end
      if (e_g1 || (!q1 && $urandom_range(0, 2) == 0)) begin
        q1 = q1 || !e_g1;
        d1 = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arbiter2.md
Name: mux_arbiter2

Overview:
- Two-requester round-robin arbiter that shares a single registered 32-bit output port between two producers.
- Example use: two pipeline stages competing for one write-back/memory bus.
- Each requester uses a req/gnt handshake. The consumer side uses valid/ready.
- The block owns both the select decision and the output holding register, so the downstream stage sees stable data until it accepts it.

Parameters:
- WIDTH, 32, data width of each requester and of the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 has valid data on data0.
- data0  input  WIDTH  requester 0 payload.
- gnt0  output  1  combinational; data0 is captured at the next rising edge.
- req1  input  1  requester 1 has valid data on data1.
- data1  input  WIDTH  requester 1 payload.
- gnt1  output  1  combinational; data1 is captured at the next rising edge.
- out_valid  output  1  out_data holds an unaccepted word.
- out_data  output  WIDTH  registered output word.
- out_src  output  1  registered; which requester out_data came from.
- out_ready  input  1  consumer accepts out_data at this edge when out_valid=1.

Behaviour:
- Reset (sync, active-high, wins over everything):
  - out_valid=0, out_data=0, out_src=0, prio=0, state=IDLE.
  - gnt0=gnt1=0 in any cycle where reset=1.
- Internal prio register selects the tie winner (0 means req0 wins a tie). After every capture, prio <= ~source_captured.
- States:
  - IDLE: out_valid=0.
  - FULL: out_valid=1, out_data and out_src held stable.
- Capture enable: cap = !reset & (state==IDLE | (state==FULL & out_ready)).
- Pick (combinational):
  - Only req0 high -> 0. Only req1 high -> 1.
  - Both high -> prio.
  - Neither high -> no pick.
- Grants: gntX = cap & reqX & (pick==X). At most one grant per cycle.
- Edge with a grant: out_data<=dataX, out_src<=X, out_valid<=1, state<=FULL.
- Edge in FULL with out_ready=1 and no grant: out_valid<=0, state<=IDLE.
- Edge in FULL with out_ready=0: hold everything. No grants are issued, and out_data is not overwritten.
- Latency: req seen in IDLE at cycle n -> gnt during cycle n -> out_valid=1 at cycle n+1.
- Back-to-back: in FULL with out_ready=1 and a pending req, accept and reload happen on the same edge. out_valid stays 1, giving one word per cycle.
- Requester contract:
  - reqX and dataX stay stable until a cycle with gntX=1.
  - After that edge, the requester may drop reqX or present the next word.
  - A requester holding req continuously gets every other slot when both are active.
- out_ready while out_valid=0 is ignored.
- Reset asserted while in FULL drops out_valid on that edge; the held word is discarded.
- Width rule: pure pass-through, with no arithmetic on data.

Decomposition:
- Shared package: state localparams (ST_IDLE=1'b0, ST_FULL=1'b1) and the default WIDTH constant.
- One sub-module is natural: rr_pick2. It is combinational, with inputs req0, req1, prio and outputs any, pick.
- The FSM, grant logic and output register stay in mux_arbiter2.

Test Plan:
1. Reset: hold reset=1 for 2 cycles while req0=1 and data0=32'd11 -> gnt0=0, out_valid=0, out_data=0 throughout; the first grant appears in the first cycle after reset is released.
2. Single requester: req0=1, data0=32'd11, out_ready=1 held -> gnt0=1 in cycle n; out_valid=1, out_data=11, out_src=0 at n+1; out_valid=0 at n+2 after req0 drops.
3. Tie and round-robin: from reset, req0=req1=1 continuously with data0=32'd12, data1=32'd40, out_ready=1 -> out_data sequence is 12, 40, 12, 40 on consecutive cycles, out_src 0, 1, 0, 1, and out_valid stays 1.
4. Backpressure: out_valid=1 with out_data=32'd110; hold out_ready=0 for 3 cycles while req1=1 with data1=32'd1 -> out_data stays 110, gnt0=gnt1=0; on the first out_ready=1 cycle gnt1=1, and the next cycle has out_data=1.
5. Reset mid-operation: in FULL with out_data=32'd40 and out_ready=0, assert reset for 1 cycle -> the next cycle has out_valid=0 and out_data=0, and the next tie goes to requester 0 because prio is back at 0.
6. Drain to idle: single word 32'd7 from req1, then out_ready=1 and no requests -> out_valid goes 1 then 0, state returns to IDLE, and a stray out_ready=1 while idle causes no change.
